// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor table arbiter: 2-bit counter
// encoding, saturating counter update and the update-entry layout.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;  // strong not-taken
    localparam ctr_t WNT = 2'b01;  // weak not-taken
    localparam ctr_t WT  = 2'b10;  // weak taken
    localparam ctr_t ST  = 2'b11;  // strong taken

    // Entry layout at the default index width; the top re-declares the same
    // {idx, taken} layout sized by its own IDX_W parameter.
    localparam int unsigned BP_IDX_W = 4;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                taken;
    } bp_upd_t;

    // Taken moves towards ST, not-taken towards SNT, both saturating.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        if (taken) begin
            nxt = (cur == ST) ? ST : ctr_t'(cur + 2'd1);
        end else begin
            nxt = (cur == SNT) ? SNT : ctr_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO buffering resolved-branch updates. DEPTH must be a power
// of two so the pointers wrap naturally. Push is ignored when full, pop when
// empty.
module bp_update_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy bookkeeping; reset drops all buffered entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // Entry storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/bp_table_arbiter.sv
// Single-ported 2-bit counter table shared between a prediction lookup port
// and a buffered resolution-update port. Lookups win the table unless the
// update FIFO is full; otherwise the FIFO head drains whenever the table is
// idle. Optional gshare indexing is enabled with the BP_GSHARE_EN macro.
module bp_table_arbiter
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    input  logic [IDX_W-1:0]              req_idx,
    output logic                          req_ready,
    output logic                          pred_valid,
    output logic                          pred_taken,
    input  logic                          upd_valid,
    input  logic [IDX_W-1:0]              upd_idx,
    input  logic                          upd_taken,
    output logic                          upd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_entry_t;

    ctr_t             table_q [ENTRIES];
    logic             pred_valid_q;
    logic             pred_taken_q;
    upd_entry_t       enq_entry;
    upd_entry_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             enq;
    logic             drain;
    logic [IDX_W-1:0] lookup_idx;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    assign lookup_idx = req_idx ^ ghr_q;
    assign enq_entry  = '{idx: upd_idx ^ ghr_q, taken: upd_taken};

    // Global history: shift in each outcome as it is accepted into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (enq) begin
            ghr_q <= {ghr_q[IDX_W-2:0], upd_taken};
        end
    end
`else
    assign lookup_idx = req_idx;
    assign enq_entry  = '{idx: upd_idx, taken: upd_taken};
`endif

    // A full FIFO takes the table away from the lookup port for one drain.
    assign req_ready = !fifo_full;
    assign upd_ready = !fifo_full;
    assign accept    = req_valid && req_ready;
    assign enq       = upd_valid && upd_ready;
    assign drain     = !fifo_empty && !accept;

    bp_update_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (upd_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (enq),
        .push_data (enq_entry),
        .pop       (drain),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Counter table: read-modify-write of the FIFO head on a drain cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= SNT;
            end
        end else if (drain) begin
            table_q[head.idx] <= ctr_next(table_q[head.idx], head.taken);
        end
    end

    // Registered prediction; the direction holds when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            pred_valid_q <= accept;
            if (accept) pred_taken_q <= table_q[lookup_idx][1];
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;

endmodule

// File: tb/tb_bp_table_arbiter.sv
// Self-checking bench for bp_table_arbiter. A cycle-level reference model
// predicts arbitration and counter contents; expected predictions go to a
// scoreboard queue and are popped when the DUT raises pred_valid.
module tb_bp_table_arbiter;
    import bp_pkg::*;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_idx = '0;
    logic       req_ready;
    logic       pred_valid;
    logic       pred_taken;
    logic       upd_valid = 1'b0;
    logic [3:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic       upd_ready;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    logic [1:0] mctr [16];
    bp_upd_t    mq [$];
    logic       sb [$];
    logic [3:0] mghr = '0;
    logic       mon_exp;

    bp_table_arbiter #(
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every pred_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && pred_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pred_unexpected got pred_valid=1 want no prediction");
            end else begin
                mon_exp = sb.pop_front();
                if (pred_taken !== mon_exp) begin
                    errors++;
                    $display("FAIL pred_taken got %0b want %0b", pred_taken, mon_exp);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mctr[i] = 2'b00;
        mq.delete();
        sb.delete();
        mghr = '0;
    endtask

    // Drive one cycle, advance the model, and return at negedge+1.
    task automatic cycle(input logic rv, input logic [3:0] ri, input logic uv,
                         input logic [3:0] ui, input logic ut);
        logic    full;
        logic    acc;
        logic    en;
        bp_upd_t e;
        req_valid = rv;
        req_idx   = ri;
        upd_valid = uv;
        upd_idx   = ui;
        upd_taken = ut;
        full = (mq.size() == DEPTH);
        acc  = rv && !full;
        en   = uv && !full;
        if (acc) sb.push_back(mctr[ri ^ mghr][1]);
        if (!acc && mq.size() != 0) begin
            e = mq.pop_front();
            if (e.taken) begin
                if (mctr[e.idx] != 2'b11) mctr[e.idx] = mctr[e.idx] + 2'd1;
            end else begin
                if (mctr[e.idx] != 2'b00) mctr[e.idx] = mctr[e.idx] - 2'd1;
            end
        end
        if (en) begin
            e.idx   = ui ^ mghr;
            e.taken = ut;
            mq.push_back(e);
`ifdef BP_GSHARE_EN
            mghr = {mghr[2:0], ut};
`endif
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 2 * DEPTH + 2 && mq.size() != 0; i++) idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_pred_valid got %0b want 0", pred_valid); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_upd_ready got %0b want 1", upd_ready); end
    endtask

    task automatic test_first_lookup();
        cycle(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL first_pred_valid got %0b want 1", pred_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL first_req_ready got %0b want 1", req_ready); end
        idle();
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL first_pred_drop got %0b want 0", pred_valid); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL first_missing got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_saturate_up();
        logic exp;
        for (int k = 0; k < 3; k++) cycle(1'b0, 4'd0, 1'b1, 4'd5, 1'b1);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL up_count got %0d want 1", fifo_count); end
        drain_all();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL up_drained got %0d want 0", fifo_count); end
        exp = mctr[4'd5 ^ mghr][1];
        cycle(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        idle();
        checks++; if (pred_valid !== 1'b0 || pred_taken !== exp) begin
            errors++; $display("FAIL up_hold got valid=%0b taken=%0b want valid=0 taken=%0b", pred_valid, pred_taken, exp);
        end
        cycle(1'b0, 4'd0, 1'b1, 4'd5, 1'b1);
        drain_all();
        cycle(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        idle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL up_missing got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_saturate_down();
        cycle(1'b0, 4'd0, 1'b1, 4'd5, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 4'd5, 1'b0);
        drain_all();
        cycle(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        idle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL down_missing got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_fifo_full();
        for (int k = 0; k < 4; k++) cycle(1'b1, 4'd1, 1'b1, 4'd9, 1'b1);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", fifo_count); end
        checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL full_upd_ready got %0b want 0", upd_ready); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_req_ready got %0b want 0", req_ready); end
        cycle(1'b1, 4'd1, 1'b1, 4'd9, 1'b0);
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_drain_count got %0d want 3", fifo_count); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_req_back got %0b want 1", req_ready); end
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL full_no_pred got %0b want 0", pred_valid); end
        drain_all();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL full_drained got %0d want 0", fifo_count); end
        cycle(1'b1, 4'd9, 1'b0, 4'd0, 1'b0);
        idle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_missing got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 4'd0, 1'b1, 4'd2, 1'b0);
        cycle(1'b1, 4'd0, 1'b1, 4'd2, 1'b0);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL sim_fill got %0d want 2", fifo_count); end
        cycle(1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL sim_count1 got %0d want 2", fifo_count); end
        cycle(1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL sim_count2 got %0d want 2", fifo_count); end
        drain_all();
        cycle(1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
        idle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sim_missing got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 4'd0, 1'b1, 4'd7, 1'b1);
        cycle(1'b0, 4'd0, 1'b1, 4'd7, 1'b1);
        drain_all();
        cycle(1'b1, 4'd7, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 4'd7, 1'b1, 4'd7, 1'b1);
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL arst_fill got %0d want 3", fifo_count); end
        req_valid = 1'b1;
        req_idx   = 4'd7;
        upd_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_pred got %0b want 1", pred_valid); end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d want 0", fifo_count); end
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL arst_pred got %0b want 0", pred_valid); end
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 1'b0, 4'd0, 1'b0);
        idle();
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL arst_cleared got %0b want 0", pred_taken); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL arst_missing got %0d pending want 0", sb.size()); end
    endtask

`ifdef BP_GSHARE_EN
    task automatic test_gshare();
        for (int k = 0; k < 3; k++) cycle(1'b0, 4'd0, 1'b1, 4'd3, 1'b1);
        // History is now 0111; these two land on counter 15 with history 1111.
        cycle(1'b0, 4'd0, 1'b1, 4'd8, 1'b1);
        cycle(1'b0, 4'd0, 1'b1, 4'd0, 1'b1);
        drain_all();
        cycle(1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        idle();
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL gshare_taken got %0b want 1", pred_taken); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL gshare_missing got %0d pending want 0", sb.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_lookup();
        test_saturate_up();
        test_saturate_down();
        test_fifo_full();
        test_simultaneous();
        test_async_reset();
`ifdef BP_GSHARE_EN
        test_gshare();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
